async_fifo_wptr_full: RTL and testbench

Write-side pointer and full-flag generator for the asynchronous FIFO. It sits directly upstream of the FIFO memory in the write clock domain. It accepts write requests, advances a binary/Gray write pointer, and drives the memory's write address and `wfull`. It also synchronizes the read-domain Gray pointer into `wclk` and derives fill level, almost-full, and an optional sticky overflow flag.

---
 rtl/async_fifo_wptr_full_if.sv | 37 +++
 rtl/async_fifo_wptr_full.sv | 111 +++++++++++
 tb/tb_async_fifo_wptr_full.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/async_fifo_wptr_full_if.sv
// Write-side bundle for the async FIFO pointer/full block.
// slave: pointer block (winc, rptr in; address, Gray pointer, flags out).
// master: producer / read-domain side driving winc and rptr.
interface async_fifo_wptr_full_if #(
    parameter int AW = 4
);
    logic          winc;
    logic [AW:0]   rptr;
    logic [AW-1:0] waddr;
    logic [AW:0]   wptr;
    logic          wfull;
    logic          wafull;
    logic [AW:0]   wlevel;
    logic          wovf;

    modport master (
        output winc,
        output rptr,
        input  waddr,
        input  wptr,
        input  wfull,
        input  wafull,
        input  wlevel,
        input  wovf
    );

    modport slave (
        input  winc,
        input  rptr,
        output waddr,
        output wptr,
        output wfull,
        output wafull,
        output wlevel,
        output wovf
    );
endinterface

// File: rtl/async_fifo_wptr_full.sv
// Async FIFO write pointer, full/almost-full/level and overflow flags.
// Ports: wclk, wrst_n (async low), bus (slave): winc, rptr -> waddr, wptr,
// wfull, wafull, wlevel, wovf. Macro ASYNC_FIFO_WOVF_EN builds sticky wovf.
module async_fifo_wptr_full #(
    parameter int D_WIDTH      = 8,
    parameter int DEPTH        = 16,
    parameter int AW           = $clog2(DEPTH),
    parameter int AFULL_THRESH = DEPTH - 2
) (
    input  logic                 wclk,
    input  logic                 wrst_n,
    async_fifo_wptr_full_if.slave bus
);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || D_WIDTH < 1 ||
        AFULL_THRESH < 1 || AFULL_THRESH > DEPTH - 1) begin : g_bad_param
        $error("async_fifo_wptr_full: illegal parameters");
    end

    localparam logic [AW:0] LP_AFULL = (AW + 1)'(AFULL_THRESH);

    logic [AW:0] r_wbin;
    logic [AW:0] r_wptr;
    logic [AW:0] r_wq1_rptr;
    logic [AW:0] r_wq2_rptr;
    logic [AW:0] r_wlevel;
    logic        r_wfull;
    logic        r_wafull;

    logic        w_accept;
    logic [AW:0] w_wbin_next;
    logic [AW:0] w_wgray_next;
    logic [AW:0] w_full_cmp;
    logic [AW:0] w_rbin_s;
    logic [AW:0] w_level_next;
    logic        w_full_next;
    logic        w_afull_next;

    // Same term the memory uses as its write enable.
    assign w_accept     = bus.winc & ~r_wfull;
    assign w_wbin_next  = r_wbin + {{AW{1'b0}}, w_accept};
    assign w_wgray_next = (w_wbin_next >> 1) ^ w_wbin_next;

    // Full when the next write pointer is one lap ahead of the synced read.
    assign w_full_cmp  = {~r_wq2_rptr[AW:AW-1], r_wq2_rptr[AW-2:0]};
    assign w_full_next = (w_wgray_next == w_full_cmp);

    always_comb begin
        w_rbin_s     = '0;
        w_rbin_s[AW] = r_wq2_rptr[AW];
        for (int i = AW - 1; i >= 0; i--) begin
            w_rbin_s[i] = w_rbin_s[i + 1] ^ r_wq2_rptr[i];
        end
    end

    // Modular difference; the stale read pointer only ever overstates.
    assign w_level_next = w_wbin_next - w_rbin_s;
    assign w_afull_next = (w_level_next >= LP_AFULL);

    // Plain two-flop synchronizer, nothing between the stages.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_wq1_rptr <= '0;
            r_wq2_rptr <= '0;
        end else begin
            r_wq1_rptr <= bus.rptr;
            r_wq2_rptr <= r_wq1_rptr;
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_wbin   <= '0;
            r_wptr   <= '0;
            r_wfull  <= 1'b0;
            r_wafull <= 1'b0;
            r_wlevel <= '0;
        end else begin
            r_wbin   <= w_wbin_next;
            r_wptr   <= w_wgray_next;
            r_wfull  <= w_full_next;
            r_wafull <= w_afull_next;
            r_wlevel <= w_level_next;
        end
    end

`ifdef ASYNC_FIFO_WOVF_EN
    logic r_wovf;

    // Sticky until reset: any write attempted while full.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            r_wovf <= 1'b0;
        end else if (bus.winc && r_wfull) begin
            r_wovf <= 1'b1;
        end
    end

    assign bus.wovf = r_wovf;
`else
    assign bus.wovf = 1'b0;
`endif

    // Address comes straight from the binary register, no adder in path.
    assign bus.waddr  = r_wbin[AW-1:0];
    assign bus.wptr   = r_wptr;
    assign bus.wfull  = r_wfull;
    assign bus.wafull = r_wafull;
    assign bus.wlevel = r_wlevel;

endmodule

// File: tb/tb_async_fifo_wptr_full.sv
// Directed bench for async_fifo_wptr_full, DEPTH=16, AFULL_THRESH=14.
// Checks reset, fill, overflow, full release, wrap and a same-edge write.
module tb_async_fifo_wptr_full;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

`ifdef ASYNC_FIFO_WOVF_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    logic wclk;
    logic wrst_n;
    int   n_run;
    int   n_fail;

    async_fifo_wptr_full_if #(.AW(AW)) bus ();

    async_fifo_wptr_full #(
        .D_WIDTH     (8),
        .DEPTH       (DEPTH),
        .AFULL_THRESH(14)
    ) dut (
        .wclk  (wclk),
        .wrst_n(wrst_n),
        .bus   (bus.slave)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    function automatic logic [AW:0] gray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_waddr"},  32'(bus.waddr),  0);
        chk({tag, "_wptr"},   32'(bus.wptr),   0);
        chk({tag, "_wfull"},  32'(bus.wfull),  0);
        chk({tag, "_wafull"}, 32'(bus.wafull), 0);
        chk({tag, "_wlevel"}, 32'(bus.wlevel), 0);
        chk({tag, "_wovf"},   32'(bus.wovf),   0);
    endtask

    logic [AW:0] prev_ptr;

    initial begin
        n_run    = 0;
        n_fail   = 0;
        wrst_n   = 1'b0;
        bus.winc = 1'b0;
        bus.rptr = '0;
        #3;
        chk_zero("rst0");
        wrst_n = 1'b1;

        // Reset in the middle of a write burst at level 5.
        bus.winc = 1'b1;
        repeat (5) tick();
        chk("pre_lvl",   32'(bus.wlevel), 5);
        chk("pre_waddr", 32'(bus.waddr),  5);
        #2;
        wrst_n = 1'b0;
        #1;
        chk_zero("rst_mid");
        wrst_n = 1'b1;
        chk("post_addr0", 32'(bus.waddr), 0);
        tick();
        chk("post_addr1", 32'(bus.waddr),  1);
        chk("post_lvl1",  32'(bus.wlevel), 1);

        // Fresh fill of 16 with rptr held at 0.
        bus.winc = 1'b0;
        wrst_n   = 1'b0;
        #1;
        wrst_n   = 1'b1;
        bus.winc = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk($sformatf("fill_afull%0d", i), 32'(bus.wafull), 32'(i >= 14));
            chk($sformatf("fill_full%0d", i),  32'(bus.wfull),  32'(i == 16));
            chk($sformatf("fill_addr%0d", i),  32'(bus.waddr),  32'(i % 16));
        end
        chk("fill_wptr",  32'(bus.wptr),   32'h18);
        chk("fill_level", 32'(bus.wlevel), 16);

        // 17th write is blocked.
        tick();
        chk("ovf_addr",  32'(bus.waddr),  0);
        chk("ovf_wptr",  32'(bus.wptr),   32'h18);
        chk("ovf_level", 32'(bus.wlevel), 16);
        chk("ovf_full",  32'(bus.wfull),  1);
        chk("ovf_flag",  32'(bus.wovf),   32'(OVF_EXP));
        bus.winc = 1'b0;

        // Read pointer moves to 1: three edges to release full.
        bus.rptr = 5'b00001;
        tick();
        chk("rel_full1", 32'(bus.wfull), 1);
        tick();
        chk("rel_full2", 32'(bus.wfull), 1);
        tick();
        chk("rel_full3",  32'(bus.wfull),  0);
        chk("rel_level",  32'(bus.wlevel), 15);
        chk("rel_afull",  32'(bus.wafull), 1);
        chk("rel_ovf",    32'(bus.wovf),   32'(OVF_EXP));

        // Write at level 15 on the edge where wq2 moves 1 -> 2.
        bus.rptr = gray(5'd2);
        tick();
        bus.winc = 1'b1;
        tick();
        bus.winc = 1'b0;
        chk("sim_addr",  32'(bus.waddr),  1);
        chk("sim_wptr",  32'(bus.wptr),   32'(gray(5'd17)));
        chk("sim_full",  32'(bus.wfull),  1);
        chk("sim_level", 32'(bus.wlevel), 16);
        tick();
        chk("sim_full2",  32'(bus.wfull),  0);
        chk("sim_level2", 32'(bus.wlevel), 15);
        chk("sim_addr2",  32'(bus.waddr),  1);

        // 40 writes with rptr one cycle behind.
        wrst_n   = 1'b0;
        bus.rptr = '0;
        #1;
        wrst_n   = 1'b1;
        bus.winc = 1'b1;
        for (int i = 0; i < 40; i++) begin
            chk($sformatf("wrap_addr%0d", i), 32'(bus.waddr), 32'(i % 16));
            prev_ptr = bus.wptr;
            tick();
            chk($sformatf("wrap_bits%0d", i),
                32'($countones(bus.wptr ^ prev_ptr)), 1);
            chk($sformatf("wrap_ptr%0d", i), 32'(bus.wptr),
                32'(gray(5'(i + 1))));
            chk($sformatf("wrap_full%0d", i), 32'(bus.wfull), 0);
            bus.rptr = gray(5'(i));
        end
        bus.winc = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
